coin_acceptor: RTL and testbench

Front-end stage ahead of `vending_machine`: turns the two raw, bouncy coin-slot sensors into clean, one-cycle coin codes on `coin_out`, which drives the vending machine's `in` port directly. Each sensor is synchronised and debounced. Qualified coins are queued and emitted one at a time, with an enforced idle gap between them. The block also flags illegal double-coin events, stuck sensors and queue overflow.

---
 rtl/coin_pkg.sv | 14 +
 rtl/coin_debounce.sv | 62 ++++++
 rtl/coin_acceptor.sv | 167 ++++++++++++++++
 tb/tb_coin_acceptor.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared coin codes and emitter state encoding for coin_acceptor and vending_machine.
package coin_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } emit_state_e;

endpackage

// File: rtl/coin_debounce.sv
// One coin sensor: 2-flop synchroniser, debounce counter, rising-edge event and jam timer.
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int JAM_CYCLES      = 64
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sense,
    output logic o_qual,
    output logic o_evt,
    output logic o_jam
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int JW = $clog2(JAM_CYCLES + 2);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [JW-1:0] JAM_LIM = JW'(JAM_CYCLES);
    localparam logic [JW-1:0] JAM_MAX = JW'(JAM_CYCLES + 1);

    logic          r_sync1, r_sync2;
    logic [DW-1:0] r_cnt;
    logic          r_qual, r_evt, r_jam;
    logic [JW-1:0] r_jcnt;

    logic          w_diff, w_flip, w_qual_nxt;
    logic [JW-1:0] w_jcnt_nxt;

    always_comb begin
        w_diff     = (r_sync2 != r_qual);
        w_flip     = w_diff && (r_cnt == DB_LAST);
        w_qual_nxt = w_flip ? r_sync2 : r_qual;
        // Timer only runs while the level stays high, so it reads 0 on the falling edge.
        w_jcnt_nxt = '0;
        if (r_qual && w_qual_nxt)
            w_jcnt_nxt = (r_jcnt == JAM_MAX) ? r_jcnt : r_jcnt + 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_qual  <= 1'b0;
            r_evt   <= 1'b0;
            r_jcnt  <= '0;
            r_jam   <= 1'b0;
        end else begin
            r_sync1 <= i_sense;
            r_sync2 <= r_sync1;
            r_cnt   <= (w_diff && !w_flip) ? r_cnt + 1'b1 : '0;
            r_qual  <= w_qual_nxt;
            r_evt   <= w_flip && r_sync2;
            r_jcnt  <= w_jcnt_nxt;
            r_jam   <= (w_jcnt_nxt > JAM_LIM);
        end
    end

    assign o_qual = r_qual;
    assign o_evt  = r_evt;
    assign o_jam  = r_jam;

endmodule

// File: rtl/coin_acceptor.sv
// Coin slot front end: two debounced sensors, arbitration, coin storage and spaced emitter.
// COIN_ACCEPTOR_FIFO_EN selects a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES      = 1,
    parameter int JAM_CYCLES      = 64,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sense5,
    input  logic       sense10,
    output logic [1:0] coin_out,
    output logic       reject,
    output logic       jam,
    output logic       overflow
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_db
        $error("DEBOUNCE_CYCLES out of range");
    end
    if (GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_bad_gap
        $error("GAP_CYCLES out of range");
    end
    if (JAM_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_jam
        $error("JAM_CYCLES must exceed DEBOUNCE_CYCLES");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two in 2..16");
    end

    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    logic w_evt5, w_evt10, w_qual5, w_qual10, w_jam5, w_jam10;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .JAM_CYCLES(JAM_CYCLES)) u_db5 (
        .i_clk(clk), .i_rst(rst), .i_sense(sense5),
        .o_qual(w_qual5), .o_evt(w_evt5), .o_jam(w_jam5)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .JAM_CYCLES(JAM_CYCLES)) u_db10 (
        .i_clk(clk), .i_rst(rst), .i_sense(sense10),
        .o_qual(w_qual10), .o_evt(w_evt10), .o_jam(w_jam10)
    );

    logic       w_push, w_rej, w_pop, w_wr, w_full, w_empty;
    logic [1:0] w_code, w_head;

    assign w_push = w_evt5 ^ w_evt10;
    assign w_rej  = w_evt5 & w_evt10;
    assign w_code = w_evt5 ? COIN_5 : COIN_10;
    // A pop in the same cycle frees a slot, so a full store still accepts the push.
    assign w_wr   = w_push && (!w_full || w_pop);

`ifdef COIN_ACCEPTOR_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [1:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wp, r_rp;

    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_head  = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= COIN_NONE;
        end else begin
            if (w_wr) begin
                r_mem[r_wp[AW-1:0]] <= w_code;
                r_wp                <= r_wp + 1'b1;
            end
            if (w_pop) r_rp <= r_rp + 1'b1;
        end
    end
`else
    logic       r_hold_vld;
    logic [1:0] r_hold_code;

    assign w_empty = !r_hold_vld;
    assign w_full  = r_hold_vld;
    assign w_head  = r_hold_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_vld  <= 1'b0;
            r_hold_code <= COIN_NONE;
        end else if (w_wr) begin
            r_hold_vld  <= 1'b1;
            r_hold_code <= w_code;
        end else if (w_pop) begin
            r_hold_vld  <= 1'b0;
        end
    end
`endif

    emit_state_e r_state, w_state_nxt;
    logic [3:0]  r_gap_cnt, w_gap_nxt;
    logic [1:0]  r_coin_out, w_coin_nxt;
    logic        r_reject, r_overflow;

    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap_cnt;
        w_coin_nxt  = COIN_NONE;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_coin_nxt  = w_head;
                    w_state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (GAP_CYCLES > 0) begin
                    w_state_nxt = GAP;
                    w_gap_nxt   = GAP_LOAD;
                end else if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_coin_nxt  = w_head;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            GAP: begin
                // Last gap cycle chains straight into EMIT so spacing stays GAP_CYCLES+1.
                if (r_gap_cnt != 4'd0) begin
                    w_gap_nxt = r_gap_cnt - 1'b1;
                end else if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_coin_nxt  = w_head;
                    w_state_nxt = EMIT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gap_cnt  <= 4'd0;
            r_coin_out <= COIN_NONE;
            r_reject   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_coin_out <= w_coin_nxt;
            r_reject   <= w_rej;
            r_overflow <= w_push && w_full && !w_pop;
        end
    end

    assign coin_out = r_coin_out;
    assign reject   = r_reject;
    assign overflow = r_overflow;
    assign jam      = (w_qual5 & w_jam5) | (w_qual10 & w_jam10);

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench: three coin_acceptor configurations against a cycle-level reference model.
module tb_coin_acceptor;

    localparam int NI = 3;
`ifdef COIN_ACCEPTOR_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    function automatic int pd(input int k); return (k == 0) ? 4 : (k == 1) ? 1 : 2; endfunction
    function automatic int pg(input int k); return (k == 0) ? 1 : (k == 1) ? 2 : 0; endfunction
    function automatic int pj(input int k); return (k == 0) ? 64 : (k == 1) ? 8 : 20; endfunction

    logic clk = 1'b0, rst = 1'b1, sense5 = 1'b0, sense10 = 1'b0;
    logic [1:0] co [NI];
    logic       rj [NI], jm [NI], ov [NI];

    always #5 clk = ~clk;

    coin_acceptor u_dut (
        .clk(clk), .rst(rst), .sense5(sense5), .sense10(sense10),
        .coin_out(co[0]), .reject(rj[0]), .jam(jm[0]), .overflow(ov[0]));
    coin_acceptor #(.DEBOUNCE_CYCLES(1), .GAP_CYCLES(2), .JAM_CYCLES(8)) u_fast (
        .clk(clk), .rst(rst), .sense5(sense5), .sense10(sense10),
        .coin_out(co[1]), .reject(rj[1]), .jam(jm[1]), .overflow(ov[1]));
    coin_acceptor #(.DEBOUNCE_CYCLES(2), .GAP_CYCLES(0), .JAM_CYCLES(20)) u_nogap (
        .clk(clk), .rst(rst), .sense5(sense5), .sense10(sense10),
        .coin_out(co[2]), .reject(rj[2]), .jam(jm[2]), .overflow(ov[2]));

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: sample history window, coin queue, and earliest-next-emit time.
    int          m_cyc [NI], m_next [NI], m_qn [NI];
    int          m_q [NI][16];
    bit          m_s1 [NI][2], m_s2 [NI][2], m_qual [NI][2], m_ev [NI][2];
    logic [255:0] m_hist [NI][2];
    int          m_ns [NI][2], m_rise [NI][2];
    int          e_coin [NI], e_rej [NI], e_jam [NI], e_ovf [NI];

    task automatic model_step(input int k, input bit s5, input bit s10, input bit r);
        bit s [2];
        bit samp, all_opp, nq;
        s[0] = s5; s[1] = s10;
        e_coin[k] = 0; e_rej[k] = 0; e_jam[k] = 0; e_ovf[k] = 0;
        if (r) begin
            m_cyc[k] = 0; m_next[k] = 0; m_qn[k] = 0;
            for (int sn = 0; sn < 2; sn++) begin
                m_s1[k][sn] = 0; m_s2[k][sn] = 0; m_qual[k][sn] = 0; m_ev[k][sn] = 0;
                m_hist[k][sn] = '0; m_ns[k][sn] = 0; m_rise[k][sn] = 0;
            end
            return;
        end
        m_cyc[k]++;
        if (m_qn[k] > 0 && m_cyc[k] >= m_next[k]) begin
            e_coin[k] = m_q[k][0];
            for (int i = 0; i < m_qn[k] - 1; i++) m_q[k][i] = m_q[k][i+1];
            m_qn[k]--;
            m_next[k] = m_cyc[k] + pg(k) + 1;
        end
        e_rej[k] = (m_ev[k][0] && m_ev[k][1]) ? 1 : 0;
        if (m_ev[k][0] != m_ev[k][1]) begin
            if (m_qn[k] < CAP) begin
                m_q[k][m_qn[k]] = m_ev[k][0] ? 1 : 2;
                m_qn[k]++;
            end else e_ovf[k] = 1;
        end
        for (int sn = 0; sn < 2; sn++) begin
            samp = m_s2[k][sn];
            m_s2[k][sn] = m_s1[k][sn];
            m_s1[k][sn] = s[sn];
            m_hist[k][sn] = {m_hist[k][sn][254:0], samp};
            if (m_ns[k][sn] < 255) m_ns[k][sn]++;
            all_opp = (m_ns[k][sn] >= pd(k));
            for (int i = 0; i < pd(k); i++)
                if (m_hist[k][sn][i] == m_qual[k][sn]) all_opp = 0;
            nq = all_opp ? !m_qual[k][sn] : m_qual[k][sn];
            m_ev[k][sn] = nq && !m_qual[k][sn];
            if (m_ev[k][sn]) m_rise[k][sn] = m_cyc[k];
            m_qual[k][sn] = nq;
            if (nq && (m_cyc[k] - m_rise[k][sn] > pj(k))) e_jam[k] = 1;
        end
    endtask

    always @(posedge clk)
        for (int k = 0; k < NI; k++) model_step(k, sense5, sense10, rst);

    int d_emit [NI], d_ovf [NI];

    always @(negedge clk)
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("coin_out[%0d]", k), co[k], e_coin[k]);
            chk($sformatf("reject[%0d]", k),   rj[k], e_rej[k]);
            chk($sformatf("jam[%0d]", k),      jm[k], e_jam[k]);
            chk($sformatf("overflow[%0d]", k), ov[k], e_ovf[k]);
            if (co[k] != 2'b00) d_emit[k]++;
            if (ov[k]) d_ovf[k]++;
        end

    // Observation of the default instance, cycles counted from the first edge after start.
    int o_first, o_code, o_cnt, o_rej, o_jon, o_joff;

    task automatic obs(input int n);
        o_first = -1; o_code = 0; o_cnt = 0; o_rej = -1; o_jon = -1; o_joff = -1;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (co[0] != 2'b00) begin
                if (o_first < 0) begin o_first = c; o_code = co[0]; end
                o_cnt++;
            end
            if (rj[0] && o_rej < 0) o_rej = c;
            if (jm[0] && o_jon < 0) o_jon = c;
            if (!jm[0] && o_jon >= 0 && o_joff < 0) o_joff = c;
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk); #1 sense5 = 0; sense10 = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic set_after(input int n, input bit a, input bit b);
        repeat (n) @(negedge clk);
        #1 sense5 = a; sense10 = b;
    endtask

    int base_e, base_o;

    initial begin
        for (int k = 0; k < NI; k++) begin d_emit[k] = 0; d_ovf[k] = 0; end
        repeat (3) @(negedge clk);
        #1 rst = 0;
        idle(5);

        // Clean 5 coin
        @(negedge clk); #1 sense5 = 1;
        fork obs(30); set_after(10, 0, 0); join
        chk("clean5_latency", o_first, pd(0) + 3);
        chk("clean5_code", o_code, 1);
        chk("clean5_count", o_cnt, 1);
        idle(10);

        // Bounce on sense10: 1,0,1,0 then high 10 cycles
        @(negedge clk); #1 sense10 = 1;
        fork
            obs(40);
            begin
                set_after(1, 0, 0); set_after(1, 0, 1); set_after(1, 0, 0);
                set_after(1, 0, 1); set_after(10, 0, 0);
            end
        join
        chk("bounce_count", o_cnt, 1);
        chk("bounce_code", o_code, 2);
        chk("bounce_latency", o_first, 4 + pd(0) + 3);
        idle(10);

        // Simultaneous sensors
        @(negedge clk); #1 sense5 = 1; sense10 = 1;
        fork obs(30); set_after(8, 0, 0); join
        chk("simul_reject_cycle", o_rej, pd(0) + 2);
        chk("simul_count", o_cnt, 0);
        idle(10);

        // Jam: sense5 high 100 cycles
        @(negedge clk); #1 sense5 = 1;
        fork obs(130); set_after(100, 0, 0); join
        chk("jam_count", o_cnt, 1);
        chk("jam_rise", o_jon, pd(0) + 1 + pj(0) + 1);
        chk("jam_fall", o_joff, 100 + 1 + pd(0));
        idle(20);

        // Burst: 16 back-to-back events on the DEBOUNCE_CYCLES=1 instance
        base_e = d_emit[1]; base_o = d_ovf[1];
        for (int c = 0; c < 16; c++) begin
            @(negedge clk); #1 sense5 = (c % 2 == 0); sense10 = (c % 2 == 1);
        end
        idle(80);
        chk("burst_conservation", (d_emit[1] - base_e) + (d_ovf[1] - base_o), 16);
        chk("burst_overflow_seen", (d_ovf[1] - base_o) > 0, 1);

        // Reset with coins queued and the emitter mid-gap
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1 sense5 = (c % 2 == 0); sense10 = (c % 2 == 1);
        end
        @(negedge clk); #1 rst = 1; sense5 = 0; sense10 = 0;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("async_rst_coin[%0d]", k), co[k], 0);
            chk($sformatf("async_rst_flags[%0d]", k), {rj[k], jm[k], ov[k]}, 0);
        end
        repeat (2) @(negedge clk);
        #1 rst = 0;
        base_e = d_emit[1];
        idle(30);
        chk("post_rst_no_stale", d_emit[1] - base_e, 0);

        // Randomised segments with occasional reset
        for (int seg = 0; seg < 220; seg++) begin
            int len;
            len = $urandom_range(1, 14);
            @(negedge clk); #1;
            if ($urandom_range(0, 60) == 0) rst = 1;
            sense5 = 1'($urandom_range(0, 1));
            sense10 = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            repeat (len) @(negedge clk);
            #1 rst = 0;
        end
        idle(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
